// File: rtl/dl11_bank_if.sv
// rtl/dl11_bank_if.sv - DCJ11-side register bus bundle for the DL11 bank
interface dl11_bank_if;
    logic [21:0] bus_addr;
    logic [1:0]  bus_bs;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_byte;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_hit;
    logic        bus_rack;

    modport master (
        output bus_addr, bus_bs, bus_rd, bus_wr, bus_byte, bus_wdata,
        input  bus_rdata, bus_hit, bus_rack
    );

    modport slave (
        input  bus_addr, bus_bs, bus_rd, bus_wr, bus_byte, bus_wdata,
        output bus_rdata, bus_hit, bus_rack
    );
endinterface

// File: rtl/dl11_bank.sv
// rtl/dl11_bank.sv - bank of DL11-style serial channels with per-channel RX/TX FIFOs
module dl11_bank #(
    parameter int          NCH     = 2,
    parameter logic [21:0] BASE    = 22'o17777560,
    parameter int          DEPTH   = 4,
    parameter int          RX_FLOW = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_init,
    dl11_bank_if.slave         bus,
    input  logic [NCH-1:0]     h_rx_valid,
    output logic [NCH-1:0]     h_rx_ready,
    input  logic [8*NCH-1:0]   h_rx_data,
    output logic [NCH-1:0]     h_tx_valid,
    input  logic [NCH-1:0]     h_tx_ready,
    output logic [8*NCH-1:0]   h_tx_data,
    output logic [NCH-1:0]     irq_rx,
    output logic [NCH-1:0]     irq_tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    rx_mem_q [NCH][DEPTH];
    logic [7:0]    rx_mem_d [NCH][DEPTH];
    logic [7:0]    tx_mem_q [NCH][DEPTH];
    logic [7:0]    tx_mem_d [NCH][DEPTH];
    logic [AW-1:0] rx_rd_q [NCH], rx_rd_d [NCH], rx_wr_q [NCH], rx_wr_d [NCH];
    logic [AW-1:0] tx_rd_q [NCH], tx_rd_d [NCH], tx_wr_q [NCH], tx_wr_d [NCH];
    logic [CW-1:0] rx_cnt_q [NCH], rx_cnt_d [NCH];
    logic [CW-1:0] tx_cnt_q [NCH], tx_cnt_d [NCH];

    logic [NCH-1:0] rie_q, rie_d, tie_q, tie_d, ovr_q, ovr_d;
    logic [NCH-1:0] irq_rx_q, irq_rx_d, irq_tx_q, irq_tx_d;
    logic [15:0]    bus_rdata_q, bus_rdata_d;
    logic           bus_rack_q, bus_rack_d;

    logic [18:0]    ch_off;
    logic           hit, rd_hit, wr_lo;
    logic [1:0]     reg_sel;
    logic [15:0]    rd_val;
    logic           wdata_unused;

    logic [NCH-1:0] sel, rx_empty, rx_full, tx_empty, tx_full;
    logic [NCH-1:0] rx_pop, rx_push, tx_pop, tx_push, ovr_set;

    // Addresses below BASE wrap to a huge offset and so fall outside the window too.
    assign ch_off  = bus.bus_addr[21:3] - BASE[21:3];
    assign hit     = (bus.bus_bs == 2'b10) && (ch_off < 19'(NCH));
    assign reg_sel = bus.bus_addr[2:1];
    assign rd_hit  = bus.bus_rd && hit;
    // Every writable bit lives in the low byte, so an odd-byte write does nothing.
    assign wr_lo   = bus.bus_wr && hit && (!bus.bus_byte || !bus.bus_addr[0]);
    assign wdata_unused = ^bus.bus_wdata[15:8];

    assign bus.bus_hit   = hit;
    assign bus.bus_rdata = bus_rdata_q;
    assign bus.bus_rack  = bus_rack_q;
    assign irq_rx        = irq_rx_q;
    assign irq_tx        = irq_tx_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign sel[g]       = hit && (ch_off == 19'(g));
        assign rx_empty[g]  = (rx_cnt_q[g] == '0);
        assign rx_full[g]   = (rx_cnt_q[g] == CW'(DEPTH));
        assign tx_empty[g]  = (tx_cnt_q[g] == '0);
        assign tx_full[g]   = (tx_cnt_q[g] == CW'(DEPTH));
        assign h_rx_ready[g] = (RX_FLOW != 0) ? !rx_full[g] : 1'b1;
        assign rx_pop[g]    = rd_hit && sel[g] && (reg_sel == 2'd1) && !rx_empty[g];
        // A same-cycle pop frees the slot, so a push onto a full FIFO still lands.
        assign rx_push[g]   = h_rx_valid[g] && h_rx_ready[g] && (!rx_full[g] || rx_pop[g]);
        assign ovr_set[g]   = h_rx_valid[g] && h_rx_ready[g] && rx_full[g] && !rx_pop[g];
        assign h_tx_valid[g] = !tx_empty[g];
        assign tx_pop[g]    = !tx_empty[g] && h_tx_ready[g];
        assign tx_push[g]   = wr_lo && sel[g] && (reg_sel == 2'd3) && (!tx_full[g] || tx_pop[g]);
        assign h_tx_data[8*g +: 8] = tx_mem_q[g][tx_rd_q[g]];
    end

    // Read data always reflects the pre-pop FIFO head.
    always_comb begin
        rd_val = '0;
        for (int n = 0; n < NCH; n++) begin
            if (sel[n]) begin
                case (reg_sel)
                    2'd0:    rd_val = {8'h00, !rx_empty[n], rie_q[n], 6'b0};
                    2'd1:    rd_val = {ovr_q[n], ovr_q[n], 6'b0,
                                       rx_empty[n] ? 8'h00 : rx_mem_q[n][rx_rd_q[n]]};
                    2'd2:    rd_val = {8'h00, !tx_full[n], tie_q[n], 6'b0};
                    default: rd_val = '0;
                endcase
            end
        end
    end

    always_comb begin
        rx_mem_d    = rx_mem_q;
        tx_mem_d    = tx_mem_q;
        rx_rd_d     = rx_rd_q;
        rx_wr_d     = rx_wr_q;
        tx_rd_d     = tx_rd_q;
        tx_wr_d     = tx_wr_q;
        rx_cnt_d    = rx_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        rie_d       = rie_q;
        tie_d       = tie_q;
        ovr_d       = ovr_q;
        irq_rx_d    = irq_rx_q;
        irq_tx_d    = irq_tx_q;
        bus_rack_d  = rd_hit;
        bus_rdata_d = rd_hit ? rd_val : bus_rdata_q;
        for (int n = 0; n < NCH; n++) begin
            if (rx_push[n]) begin
                rx_mem_d[n][rx_wr_q[n]] = h_rx_data[8*n +: 8];
                rx_wr_d[n] = rx_wr_q[n] + 1'b1;
            end
            if (rx_pop[n]) begin
                rx_rd_d[n] = rx_rd_q[n] + 1'b1;
            end
            rx_cnt_d[n] = rx_cnt_q[n] + CW'(rx_push[n]) - CW'(rx_pop[n]);

            if (tx_push[n]) begin
                tx_mem_d[n][tx_wr_q[n]] = bus.bus_wdata[7:0];
                tx_wr_d[n] = tx_wr_q[n] + 1'b1;
            end
            if (tx_pop[n]) begin
                tx_rd_d[n] = tx_rd_q[n] + 1'b1;
            end
            tx_cnt_d[n] = tx_cnt_q[n] + CW'(tx_push[n]) - CW'(tx_pop[n]);

            if (rd_hit && sel[n] && (reg_sel == 2'd1)) begin
                ovr_d[n] = 1'b0;
            end
            if (ovr_set[n]) begin
                ovr_d[n] = 1'b1;
            end
            if (wr_lo && sel[n] && (reg_sel == 2'd0)) begin
                rie_d[n] = bus.bus_wdata[6];
            end
            if (wr_lo && sel[n] && (reg_sel == 2'd2)) begin
                tie_d[n] = bus.bus_wdata[6];
            end
            // Built from next-state values so the request follows its cause by one cycle.
            irq_rx_d[n] = rie_d[n] && (rx_cnt_d[n] != '0);
            irq_tx_d[n] = tie_d[n] && (tx_cnt_d[n] != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus_init) begin
            for (int n = 0; n < NCH; n++) begin
                rx_rd_q[n]  <= '0;
                rx_wr_q[n]  <= '0;
                tx_rd_q[n]  <= '0;
                tx_wr_q[n]  <= '0;
                rx_cnt_q[n] <= '0;
                tx_cnt_q[n] <= '0;
            end
            rie_q       <= '0;
            tie_q       <= '0;
            ovr_q       <= '0;
            irq_rx_q    <= '0;
            irq_tx_q    <= '0;
            bus_rdata_q <= '0;
            bus_rack_q  <= 1'b0;
        end else begin
            rx_rd_q     <= rx_rd_d;
            rx_wr_q     <= rx_wr_d;
            tx_rd_q     <= tx_rd_d;
            tx_wr_q     <= tx_wr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            rie_q       <= rie_d;
            tie_q       <= tie_d;
            ovr_q       <= ovr_d;
            irq_rx_q    <= irq_rx_d;
            irq_tx_q    <= irq_tx_d;
            bus_rdata_q <= bus_rdata_d;
            bus_rack_q  <= bus_rack_d;
        end
    end

    // Storage needs no reset; the emptied pointers make stale bytes unreachable.
    always_ff @(posedge clk) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end
endmodule

// File: tb/tb_dl11_bank.sv
// tb/tb_dl11_bank.sv - directed self-checking bench for dl11_bank
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))

module tb_dl11_bank;
    localparam logic [21:0] BASE = 22'o17777560;

    logic clk = 1'b0;
    logic rst, bus_init0, bus_init1;
    always #5 clk = ~clk;

    dl11_bank_if if0();
    dl11_bank_if if1();

    logic [1:0]  rxv0, rxr0, txv0, txr0, irqr0, irqt0;
    logic [15:0] rxd0, txd0;
    logic [0:0]  rxv1, rxr1, txv1, txr1, irqr1, irqt1;
    logic [7:0]  rxd1, txd1;

    int errors = 0;
    int checks = 0;
    logic [7:0] tx_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    dl11_bank #(.NCH(2), .BASE(BASE), .DEPTH(4), .RX_FLOW(1)) u0 (
        .clk(clk), .rst(rst), .bus_init(bus_init0), .bus(if0),
        .h_rx_valid(rxv0), .h_rx_ready(rxr0), .h_rx_data(rxd0),
        .h_tx_valid(txv0), .h_tx_ready(txr0), .h_tx_data(txd0),
        .irq_rx(irqr0), .irq_tx(irqt0)
    );

    dl11_bank #(.NCH(1), .BASE(BASE), .DEPTH(4), .RX_FLOW(0)) u1 (
        .clk(clk), .rst(rst), .bus_init(bus_init1), .bus(if1),
        .h_rx_valid(rxv1), .h_rx_ready(rxr1), .h_rx_data(rxd1),
        .h_tx_valid(txv1), .h_tx_ready(txr1), .h_tx_data(txd1),
        .irq_rx(irqr1), .irq_tx(irqt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic [21:0] a, input logic [1:0] bs,
                         input logic rd, input logic wr, input logic byt, input logic [15:0] wd);
        if (d == 0) begin
            if0.bus_addr = a; if0.bus_bs = bs; if0.bus_rd = rd;
            if0.bus_wr = wr; if0.bus_byte = byt; if0.bus_wdata = wd;
        end else begin
            if1.bus_addr = a; if1.bus_bs = bs; if1.bus_rd = rd;
            if1.bus_wr = wr; if1.bus_byte = byt; if1.bus_wdata = wd;
        end
    endtask

    task automatic idle(input int d);
        drive(d, 22'd0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic rd(input int d, input logic [21:0] a, input logic [15:0] exp, input string tag);
        drive(d, a, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        `CHK({tag, " rack"}, (d == 0) ? if0.bus_rack : if1.bus_rack, 1'b1);
        `CHK(tag, (d == 0) ? if0.bus_rdata : if1.bus_rdata, exp);
        idle(d);
    endtask

    task automatic wr(input int d, input logic [21:0] a, input logic byt, input logic [15:0] wd);
        drive(d, a, 2'b10, 1'b0, 1'b1, byt, wd);
        @(negedge clk);
        idle(d);
    endtask

    task automatic push(input int d, input int ch, input logic [7:0] b);
        if (d == 0) begin
            rxv0[ch] = 1'b1;
            rxd0[8*ch +: 8] = b;
        end else begin
            rxv1[0] = 1'b1;
            rxd1 = b;
        end
        @(negedge clk);
        rxv0 = '0;
        rxv1 = '0;
    endtask

    initial begin
        rst = 1'b1; bus_init0 = 1'b0; bus_init1 = 1'b0;
        rxv0 = '0; rxd0 = '0; txr0 = '0; rxv1 = '0; rxd1 = '0; txr1 = '0;
        idle(0); idle(1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        checks++;
        if (if0.bus_rack !== 1'b0) begin
            errors++;
            $error("FAIL rst rack: got %0h", if0.bus_rack);
        end
        checks++;
        if (if0.bus_rdata !== 16'h0000) begin
            errors++;
            $error("FAIL rst rdata: got %0h", if0.bus_rdata);
        end
        checks++;
        if (txv0 !== 2'b00) begin
            errors++;
            $error("FAIL rst tx_valid: got %0h", txv0);
        end
        checks++;
        if (rxr0 !== 2'b11) begin
            errors++;
            $error("FAIL rst rx_ready: got %0h", rxr0);
        end
        checks++;
        if (rxr1 !== 1'b1) begin
            errors++;
            $error("FAIL rst rx_ready flow0: got %0h", rxr1);
        end
        checks++;
        if ({irqr0, irqt0, irqr1, irqt1} !== 6'b0) begin
            errors++;
            $error("FAIL rst irq: got %0h", {irqr0, irqt0, irqr1, irqt1});
        end

        drive(0, BASE, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0); #1;
        `CHK("hit base", if0.bus_hit, 1'b1);
        drive(0, BASE + 22'd14, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0); #1;
        `CHK("hit ch1 top", if0.bus_hit, 1'b1);
        drive(0, BASE + 22'd16, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0); #1;
        `CHK("hit past end", if0.bus_hit, 1'b0);
        drive(0, BASE - 22'd2, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0); #1;
        `CHK("hit below base", if0.bus_hit, 1'b0);
        drive(0, BASE, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0); #1;
        `CHK("hit bs00", if0.bus_hit, 1'b0);
        drive(1, BASE + 22'd8, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0); #1;
        `CHK("hit nch1 ch1", if1.bus_hit, 1'b0);
        idle(0); idle(1);

        wr(0, BASE + 22'd22, 1'b0, 16'h0055);
        `CHK("nxm no push", txv0, 2'b00);
        drive(0, BASE + 22'd16, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        `CHK("nxm no rack", if0.bus_rack, 1'b0);
        idle(0);

        push(0, 1, 8'h41);
        rd(0, BASE + 22'd8, 16'h0080, "ch1 rcsr done");
        rd(0, BASE, 16'h0000, "ch0 rcsr idle");
        rd(0, BASE + 22'd10, 16'h0041, "ch1 rbuf");
        @(negedge clk);
        `CHK("rack single pulse", if0.bus_rack, 1'b0);
        `CHK("rdata held", if0.bus_rdata, 16'h0041);
        rd(0, BASE + 22'd8, 16'h0000, "ch1 rcsr after pop");
        rd(0, BASE + 22'd10, 16'h0000, "ch1 rbuf empty");

        wr(0, BASE + 22'd7, 1'b1, 16'h9900);
        `CHK("odd xbuf byte", txv0, 2'b00);
        wr(0, BASE + 22'd6, 1'b0, 16'h0011);
        wr(0, BASE + 22'd6, 1'b0, 16'h1222);
        wr(0, BASE + 22'd6, 1'b1, 16'hAA33);
        rd(0, BASE + 22'd4, 16'h0080, "xcsr rdy after 3");
        wr(0, BASE + 22'd6, 1'b0, 16'h0044);
        rd(0, BASE + 22'd4, 16'h0000, "xcsr full");
        wr(0, BASE + 22'd6, 1'b0, 16'h0055);
        `CHK("tx head", txd0[7:0], 8'h11);
        `CHK("ch1 tx idle", txv0[1], 1'b0);
        txr0[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (txv0[0] !== 1'b1) begin
                errors++;
                $error("FAIL tx drain valid %0d: got %0h", i, txv0[0]);
            end
            checks++;
            if (txd0[7:0] !== tx_exp[i]) begin
                errors++;
                $error("FAIL tx drain data %0d: got %0h expected %0h", i, txd0[7:0], tx_exp[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (txv0[0] !== 1'b0) begin
            errors++;
            $error("FAIL tx drained: got %0h", txv0[0]);
        end
        txr0[0] = 1'b0;

        push(0, 0, 8'h5A);
        `CHK("irq_rx without rie", irqr0, 2'b00);
        wr(0, BASE, 1'b0, 16'h0040);
        `CHK("irq_rx raised", irqr0, 2'b01);
        rd(0, BASE, 16'h00C0, "rcsr rie done");
        rd(0, BASE + 22'd2, 16'h005A, "rbuf 5a");
        `CHK("irq_rx dropped", irqr0, 2'b00);
        wr(0, BASE + 22'd12, 1'b0, 16'h0040);
        `CHK("irq_tx ch1", irqt0, 2'b10);
        wr(0, BASE + 22'd5, 1'b1, 16'h4040);
        `CHK("odd xcsr byte", irqt0, 2'b10);
        rd(0, BASE + 22'd4, 16'h0080, "ch0 xcsr");

        for (int i = 1; i <= 4; i++) push(0, 0, 8'(i));
        `CHK("rx full backpressure", rxr0, 2'b10);
        push(0, 0, 8'h05);
        rd(0, BASE + 22'd2, 16'h0001, "rbuf bp first");
        `CHK("rx ready again", rxr0, 2'b11);
        rd(0, BASE + 22'd2, 16'h0002, "rbuf bp 2");
        rd(0, BASE + 22'd2, 16'h0003, "rbuf bp 3");
        rd(0, BASE + 22'd2, 16'h0004, "rbuf bp 4");
        rd(0, BASE, 16'h0040, "rcsr drained");

        push(0, 1, 8'h77);
        rd(0, BASE + 22'd8, 16'h0080, "ch1 rcsr pre-init");
        drive(0, BASE + 22'd10, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0);
        bus_init0 = 1'b1;
        @(negedge clk);
        bus_init0 = 1'b0;
        idle(0);
        checks++;
        if (if0.bus_rack !== 1'b0) begin
            errors++;
            $error("FAIL init rack: got %0h", if0.bus_rack);
        end
        checks++;
        if (if0.bus_rdata !== 16'h0000) begin
            errors++;
            $error("FAIL init rdata: got %0h", if0.bus_rdata);
        end
        checks++;
        if (irqt0 !== 2'b00) begin
            errors++;
            $error("FAIL init irq_tx: got %0h", irqt0);
        end
        rd(0, BASE + 22'd8, 16'h0000, "ch1 rcsr post-init");
        rd(0, BASE + 22'd12, 16'h0080, "ch1 xcsr post-init");
        rd(0, BASE, 16'h0000, "ch0 rcsr post-init");

        for (int i = 0; i < 5; i++) push(1, 0, 8'(8'hA0 + i));
        `CHK("flow0 ready", rxr1, 1'b1);
        rd(1, BASE + 22'd2, 16'hC0A0, "rbuf ovr");
        rd(1, BASE + 22'd2, 16'h00A1, "rbuf ovr cleared");
        push(1, 0, 8'hA5);
        push(1, 0, 8'hA6);
        drive(1, BASE + 22'd2, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0);
        rxv1 = 1'b1; rxd1 = 8'hB0;
        @(negedge clk);
        rxv1 = 1'b0;
        idle(1);
        checks++;
        if (if1.bus_rack !== 1'b1) begin
            errors++;
            $error("FAIL full pop+push rack: got %0h", if1.bus_rack);
        end
        checks++;
        if (if1.bus_rdata !== 16'h00A2) begin
            errors++;
            $error("FAIL full pop+push data: got %0h", if1.bus_rdata);
        end
        rd(1, BASE + 22'd2, 16'h00A3, "full order 1");
        rd(1, BASE + 22'd2, 16'h00A5, "full order 2");
        rd(1, BASE + 22'd2, 16'h00A6, "full order 3");
        rd(1, BASE + 22'd2, 16'h00B0, "full order 4");
        rd(1, BASE, 16'h0000, "flow0 empty rcsr");

        drive(1, BASE + 22'd2, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0);
        rxv1 = 1'b1; rxd1 = 8'hC1;
        @(negedge clk);
        rxv1 = 1'b0;
        idle(1);
        `CHK("empty pop+push data", if1.bus_rdata, 16'h0000);
        rd(1, BASE + 22'd2, 16'h00C1, "empty push kept");
        rd(1, BASE, 16'h0000, "flow0 rcsr after");

        wr(1, BASE + 22'd6, 1'b0, 16'h00E7);
        checks++;
        if (txv1 !== 1'b1) begin
            errors++;
            $error("FAIL flow0 tx valid: got %0h", txv1);
        end
        checks++;
        if (txd1 !== 8'hE7) begin
            errors++;
            $error("FAIL flow0 tx data: got %0h", txd1);
        end
        txr1 = 1'b1;
        @(negedge clk);
        txr1 = 1'b0;
        `CHK("flow0 tx drained", txv1, 1'b0);
        `CHK("flow0 irq idle", {irqr1, irqt1}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dl11_bank.md
DL11_BANK -- requirements
Module: dl11_bank

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning the number of DL11-style serial channels (1..4).
REQ-002 SHALL have parameter BASE, default 22'o17777560, meaning the 22-bit physical address of channel 0 RCSR; channel n sits at BASE+8n.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the RX and TX FIFO depth per channel (power of 2, 2..16).
REQ-004 SHALL have parameter RX_FLOW, default 1, meaning RX mode: 1 = backpressure the host, 0 = accept and drop on full, setting OVR.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port bus_init, input, 1 bit: single-cycle pulse from the DCJ11 RESET (GP code 014).
REQ-008 SHALL have ports bus_addr (input, 22 bits) and bus_bs (input, 2 bits): latched DAL address and bank select.
REQ-009 SHALL have ports bus_rd, bus_wr, bus_byte (inputs, 1 bit each): single-cycle read and write strobes, and byte-write qualifier.
REQ-010 SHALL have ports bus_wdata (input, 16 bits) and bus_rdata (output, 16 bits): write data and registered read data.
REQ-011 SHALL have ports bus_hit (output, 1 bit, combinational) and bus_rack (output, 1 bit): address decode for NXM and the read-data-valid pulse.
REQ-012 SHALL have ports h_rx_valid (input, NCH bits), h_rx_ready (output, NCH bits) and h_rx_data (input, 8*NCH bits): host-to-PDP byte stream per channel.
REQ-013 SHALL have ports h_tx_valid (output, NCH bits), h_tx_ready (input, NCH bits) and h_tx_data (output, 8*NCH bits): PDP-to-host byte stream per channel.
REQ-014 SHALL have ports irq_rx and irq_tx (outputs, NCH bits each): level interrupt requests.

Function
REQ-015 SHALL assert bus_hit combinationally iff bus_bs==2'b10 and bus_addr[21:3] is within BASE[21:3]..BASE[21:3]+NCH-1.
REQ-016 SHALL decode bus_addr[2:1] as 0=RCSR, 1=RBUF, 2=XCSR, 3=XBUF, and SHALL ignore strobes when bus_hit=0.
REQ-017 SHALL present RCSR as {8'b0, DONE=(RX FIFO not empty), RIE, 6'b0}; bit 6 is read/write, all other bits are read-only.
REQ-018 SHALL present RBUF as {ERR, OVR, 6'b0, RX FIFO head}; ERR equals OVR; reads 8'h00 in the data field when the FIFO is empty.
REQ-019 SHALL pop the RX FIFO and clear OVR on an RBUF read; a read of an empty FIFO SHALL NOT pop.
REQ-020 SHALL present XCSR as {8'b0, RDY=(TX FIFO not full), TIE, 6'b0}; bit 6 is read/write.
REQ-021 SHALL push bus_wdata[7:0] into the TX FIFO on an XBUF write (word, or byte at an even address); a write while full SHALL be dropped with no state change.
REQ-022 SHALL apply byte writes only to the addressed byte (bus_addr[0]); odd-byte writes to CSRs and XBUF SHALL have no effect.
REQ-023 SHALL register bus_rdata and pulse bus_rack exactly 1 cycle after a hit bus_rd; bus_rdata SHALL hold its value until the next read.
REQ-024 SHALL ensure pop side effects are based on pre-pop contents: the returned data is the head before the pop.
REQ-025 SHALL, with RX_FLOW=1, drive h_rx_ready = RX FIFO not full and push on h_rx_valid&h_rx_ready.
REQ-026 SHALL, with RX_FLOW=0, hold h_rx_ready=1, push when not full, and set OVR when full (byte dropped).
REQ-027 SHALL drive h_tx_valid = TX FIFO not empty with h_tx_data = head, and pop on h_tx_valid&h_tx_ready.
REQ-028 SHALL handle simultaneous push and pop on a full FIFO: the pop frees a slot, the push is accepted, count is unchanged, and OVR is not set.
REQ-029 SHALL handle simultaneous push and pop on an empty FIFO: the push is stored, the pop is ignored, and count becomes 1.
REQ-030 SHALL use DEPTH-wrapping FIFO pointers with a log2(DEPTH)+1-bit count; full means count==DEPTH.
REQ-031 SHALL register irq_rx[n] = RIE & DONE and irq_tx[n] = TIE & RDY, updated 1 cycle after the cause; setting IE while the condition holds raises irq on the next cycle.
REQ-032 SHALL operate channels independently; an access to one channel SHALL NOT alter another.

Reset
REQ-033 SHALL, on rst, empty all FIFOs and clear RIE, TIE, OVR, bus_rdata, bus_rack, irq_rx and irq_tx; h_tx_valid=0 and h_rx_ready=RX_FLOW?1:1 on the next cycle.
REQ-034 SHALL give bus_init identical effect to rst; rst or bus_init SHALL take priority over any same-cycle bus or host event, and an in-flight read returns 0 with no rack.

Verification
REQ-035 SHALL pass this case: NCH=2; host pushes 8'h41 on ch1; RBUF read at BASE+8+2 -> rack after 1 cycle, rdata=16'h0041; RCSR ch1 then reads 16'h0000.
REQ-036 SHALL pass this case: DEPTH=4; write XBUF 5 times while h_tx_ready=0 -> XCSR bit7=0 after the 4th write; the 5th is dropped; host drains 4 bytes in order.
REQ-037 SHALL pass this case: RX_FLOW=0; push 5 bytes with no reads -> RBUF=16'hC0xx (ERR, OVR, first byte); after a read, the next RBUF read has bits 15:14 = 0.
REQ-038 SHALL pass this case: write RCSR 16'h0040 with RX FIFO non-empty -> irq_rx=1 next cycle; read RBUF to empty -> irq_rx=0 one cycle later.
REQ-039 SHALL pass this case: bus_addr=BASE+16 with NCH=2 -> bus_hit=0, no state change; bus_bs=2'b00 at BASE -> bus_hit=0.
REQ-040 SHALL pass this case: full RX FIFO with a same-cycle RBUF read and host push -> count stays DEPTH, OVR=0, and the data order is preserved.
